sort_stream_loader: RTL and testbench

Upstream stage of the odd-even merge sorting network. It accepts elements one per cycle over a valid/ready stream and assembles them into the sorter's wide parallel input vector. It pads short frames (ended by `s_last` or `flush`) with a sentinel value that sorts to the tail. It then issues a single-cycle `x_valid` strobe together with the count of real elements. Back-to-back frames run with no bubble: N elements every N cycles.

---
 rtl/sort_stream_loader_pkg.sv | 26 ++
 rtl/sort_stream_loader.sv | 93 +++++++++
 tb/tb_sort_stream_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sort_stream_loader_pkg.sv
// Shared definitions for the sorting-network stream stages (loader, sorter, unloader).
//   frame_slots : number of parallel slots N = 2**log_input
//   sort_pad    : pad value that sorts to the tail of a frame for the given
//                 signedness / direction; returned LSB-aligned in PAD_MAX_W bits
package sort_stream_loader_pkg;

  localparam int unsigned PAD_MAX_W = 256;

  function automatic int unsigned frame_slots(int unsigned log_input);
    return 32'd1 << log_input;
  endfunction

  // Ascending: largest value (all ones, or max positive when signed).
  // Descending: smallest value (all zeros, or most negative when signed).
  function automatic logic [PAD_MAX_W-1:0] sort_pad(bit is_signed, bit ascending,
                                                    int unsigned width);
    logic [PAD_MAX_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < PAD_MAX_W; i++) begin
      if (i < width) p[i] = ascending;
    end
    if (is_signed && width > 0) p[width-1] = ~ascending;
    return p;
  endfunction

endpackage

// File: rtl/sort_stream_loader.sv
// sort_stream_loader: collects one element per cycle from a valid/ready stream
// into the sorter's wide parallel input, pads short frames with a tail-sorting
// value and strobes x_valid for one cycle with the count of real elements.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_valid/s_ready input stream handshake (s_ready is 1 from the first edge after reset)
//   s_data, s_last  element and end-of-frame marker
//   flush           close the current partial frame (no effect when it is empty)
//   x               collection buffer / frame to sorter, slot i at x[i*DATA_WIDTH +: DATA_WIDTH]
//   x_valid         one-cycle strobe: x holds a complete frame
//   x_count         real elements in the frame (1..N), valid with x_valid
//   frames_out      frames emitted, wraps at 2**16
module sort_stream_loader
  import sort_stream_loader_pkg::*;
#(
  parameter int unsigned LOG_INPUT  = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          ASCENDING  = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [DATA_WIDTH-1:0]                 s_data,
  input  logic                                  s_last,
  input  logic                                  flush,
  output logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]  x,
  output logic                                  x_valid,
  output logic [LOG_INPUT:0]                    x_count,
  output logic [15:0]                           frames_out
);

  localparam int unsigned N = frame_slots(LOG_INPUT);
  localparam logic [PAD_MAX_W-1:0] PAD_FULL = sort_pad(SIGNED, ASCENDING, DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] PAD = PAD_FULL[DATA_WIDTH-1:0];
  localparam logic [LOG_INPUT-1:0] IDX_LAST = LOG_INPUT'(N - 1);

  logic [LOG_INPUT-1:0] idx;
  logic                 accept;
  logic                 close_acc;
  logic                 close_flush;
  logic [N-1:0]         wr_en;
  logic [N-1:0]         pad_en;

  assign accept      = s_valid & s_ready;
  // flush during an accept behaves like s_last on that element
  assign close_acc   = accept & (s_last | flush | (idx == IDX_LAST));
  // flush on an idle cycle closes the frame before slot idx, which gets padded
  assign close_flush = flush & ~accept & (idx != '0);

  for (genvar j = 0; j < N; j++) begin : g_slot
    localparam logic [LOG_INPUT-1:0] J = LOG_INPUT'(j);
    assign wr_en[j]  = accept && (idx == J);
    assign pad_en[j] = (close_acc && (J > idx)) || (close_flush && (J >= idx));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
    end else begin
      for (int unsigned j = 0; j < N; j++) begin
        if (wr_en[j]) x[j*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        else if (pad_en[j]) x[j*DATA_WIDTH +: DATA_WIDTH] <= PAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      s_ready    <= 1'b0;
      x_valid    <= 1'b0;
      x_count    <= '0;
      frames_out <= '0;
    end else begin
      s_ready <= 1'b1;
      x_valid <= close_acc | close_flush;
      if (close_acc) begin
        idx        <= '0;
        x_count    <= {1'b0, idx} + 1'b1;
        frames_out <= frames_out + 16'd1;
      end else if (close_flush) begin
        idx        <= '0;
        x_count    <= {1'b0, idx};
        frames_out <= frames_out + 16'd1;
      end else if (accept) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sort_stream_loader.sv
// Bench for sort_stream_loader with N=4, 8-bit elements. Two instances share
// the stimulus: unsigned ascending (pad FF) and signed descending (pad 80).
module tb_sort_stream_loader;

  localparam int unsigned LOG_INPUT = 2;
  localparam int unsigned N = 4;
  localparam int unsigned DW = 8;
  localparam logic [7:0] PAD_U = 8'hFF;
  localparam logic [7:0] PAD_S = 8'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        flush = 1'b0;

  logic        ready_u, ready_s;
  logic [31:0] x_u, x_s;
  logic        xv_u, xv_s;
  logic [2:0]  cnt_u, cnt_s;
  logic [15:0] fo_u, fo_s;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int strobes[$];

  sort_stream_loader #(.LOG_INPUT(LOG_INPUT), .DATA_WIDTH(DW), .SIGNED(1'b0), .ASCENDING(1'b1)) dut_u (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready_u), .s_data(s_data),
    .s_last(s_last), .flush(flush), .x(x_u), .x_valid(xv_u), .x_count(cnt_u),
    .frames_out(fo_u));

  sort_stream_loader #(.LOG_INPUT(LOG_INPUT), .DATA_WIDTH(DW), .SIGNED(1'b1), .ASCENDING(1'b0)) dut_s (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready_s), .s_data(s_data),
    .s_last(s_last), .flush(flush), .x(x_s), .x_valid(xv_s), .x_count(cnt_s),
    .frames_out(fo_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model: a frame is a queue of elements ----------------
  logic [7:0] cur[$];
  logic [7:0] ed[N];
  bit         m_ready;
  bit         exp_valid;
  int         exp_cnt;
  int         exp_frames;

  task automatic close_frame();
    exp_cnt = cur.size();
    for (int i = 0; i < int'(N); i++) ed[i] = (i < exp_cnt) ? cur[i] : 8'h00;
    cur.delete();
    exp_valid = 1'b1;
    exp_frames++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cur.delete();
      m_ready = 1'b0;
      exp_valid = 1'b0;
      exp_cnt = 0;
      exp_frames = 0;
    end else begin
      exp_valid = 1'b0;
      if (s_valid && m_ready) begin
        cur.push_back(s_data);
        if (s_last || flush || cur.size() == int'(N)) close_frame();
      end else if (flush && cur.size() > 0) begin
        close_frame();
      end
      m_ready = 1'b1;
    end
  end

  function automatic logic [31:0] frame_x(logic [7:0] pad);
    logic [31:0] v;
    for (int i = 0; i < int'(N); i++) v[i*8 +: 8] = (i < exp_cnt) ? ed[i] : pad;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (xv_u) strobes.push_back(cyc);
    check("s_ready_u", 64'(ready_u), 64'(m_ready));
    check("s_ready_s", 64'(ready_s), 64'(m_ready));
    check("x_valid_u", 64'(xv_u), 64'(exp_valid));
    check("x_valid_s", 64'(xv_s), 64'(exp_valid));
    check("frames_u", 64'(fo_u), 64'(exp_frames[15:0]));
    check("frames_s", 64'(fo_s), 64'(exp_frames[15:0]));
    if (exp_valid) begin
      check("x_count_u", 64'(cnt_u), 64'(exp_cnt));
      check("x_count_s", 64'(cnt_s), 64'(exp_cnt));
      check("x_u", 64'(x_u), 64'(frame_x(PAD_U)));
      check("x_s", 64'(x_s), 64'(frame_x(PAD_S)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input bit last, input bit fl);
    s_valid = 1'b1; s_data = d; s_last = last; flush = fl;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    // reset release
    idle(3);
    check("rst_ready", 64'(ready_u), 64'd0);
    check("rst_x", 64'(x_u), 64'd0);
    check("rst_count", 64'(cnt_u), 64'd0);
    check("rst_valid", 64'(xv_u), 64'd0);
    check("rst_frames", 64'(fo_u), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 64'(ready_u), 64'd0);
    idle(1);
    check("ready_after_edge", 64'(ready_u), 64'd1);

    // full frame 5,3,9,1
    send(8'd5, 0, 0); send(8'd3, 0, 0); send(8'd9, 0, 0); send(8'd1, 0, 0);
    check("f1_valid", 64'(xv_u), 64'd1);
    check("f1_x", 64'(x_u), 64'h01_09_03_05);
    check("f1_count", 64'(cnt_u), 64'd4);
    check("f1_frames", 64'(fo_u), 64'd1);
    idle(2);

    // short frame 7,2 with s_last
    send(8'd7, 0, 0); send(8'd2, 1, 0);
    check("f2_x", 64'(x_u), 64'hFF_FF_02_07);
    check("f2_count", 64'(cnt_u), 64'd2);
    check("f2_x_signed", 64'(x_s), 64'h80_80_02_07);
    idle(1);

    // single element then flush, then a flush on an empty frame
    send(8'd4, 0, 0);
    idle(3);
    do_flush();
    check("f3_valid", 64'(xv_u), 64'd1);
    check("f3_x", 64'(x_u), 64'hFF_FF_FF_04);
    check("f3_count", 64'(cnt_u), 64'd1);
    idle(1);
    do_flush();
    check("empty_flush_valid", 64'(xv_u), 64'd0);
    check("empty_flush_frames", 64'(fo_u), 64'd3);
    idle(1);

    // eight back-to-back accepts
    strobes.delete();
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 0, 0);
      if (i == 4) check("b2b_first", 64'(x_u), 64'h04_03_02_01);
      if (i == 8) check("b2b_second", 64'(x_u), 64'h08_07_06_05);
    end
    idle(1);
    check("b2b_strobes", 64'(strobes.size()), 64'd2);
    if (strobes.size() == 2) check("b2b_spacing", 64'(strobes[1] - strobes[0]), 64'd4);

    // back-to-back single-element frames
    send(8'h11, 1, 0); send(8'h22, 1, 0);
    check("single_x", 64'(x_u), 64'hFF_FF_FF_22);
    // flush together with an accept closes on that element
    send(8'h33, 0, 0); send(8'h44, 0, 1);
    check("flush_acc_count", 64'(cnt_u), 64'd2);
    check("flush_acc_x", 64'(x_u), 64'hFF_FF_44_33);
    idle(1);

    // three elements then s_last: signed descending pads with 80
    send(8'h0A, 0, 0); send(8'h14, 0, 0); send(8'h1E, 1, 0);
    check("sig_x", 64'(x_s), 64'h80_1E_14_0A);
    check("sig_count", 64'(cnt_s), 64'd3);
    check("uns_x", 64'(x_u), 64'hFF_1E_14_0A);
    idle(1);

    // reset mid-frame discards the partial frame
    send(8'h55, 0, 0); send(8'h66, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(xv_u), 64'd0);
    check("midrst_frames", 64'(fo_u), 64'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    send(8'h09, 1, 0);
    check("after_rst_x", 64'(x_u), 64'hFF_FF_FF_09);
    check("after_rst_count", 64'(cnt_u), 64'd1);
    check("after_rst_frames", 64'(fo_u), 64'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog bench did not complete, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
